// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage sitting directly after the PC register. For every instruction it
// issues one read on an SRAM-like instruction bus (address phase, then data phase) and
// presents the fetched word, tagged with its PC, to the IF/ID boundary. The PC register only
// advances when an instruction is handed off (pc_en_o). A flush while a bus transaction is
// outstanding lets the transaction finish and throws the returned word away. A misaligned PC
// produces an address-error instruction without touching the bus.
//
// Parameters:
//   RESET_PC         value of inst_pc_o after reset
//   MAX_WAIT         bus-phase wait limit in cycles; only drives fetch_timeout_o
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   pc_i             current PC from the PC register (sampled only in IDLE)
//   flush            pipeline flush; PC register loads the new PC on the same edge
//   stall_i          decode cannot accept an instruction this cycle
//   pc_en_o          advance enable to the PC register (combinational)
//   ibus_req_o       bus address-phase request
//   ibus_addr_o      bus address, word-aligned, stable while ibus_req_o=1
//   ibus_addr_ok_i   address phase accepted
//   ibus_data_ok_i   read data valid
//   ibus_rdata_i     read data
//   inst_valid_o     inst_o / inst_pc_o / inst_exc_adel_o are valid
//   inst_o           fetched instruction (0 when inst_exc_adel_o=1)
//   inst_pc_o        PC of inst_o
//   inst_exc_adel_o  address error on fetch
//   fetch_timeout_o  sticky: a bus phase waited MAX_WAIT cycles
// ---------------------------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        flush,
    input  logic        stall_i,
    output logic        pc_en_o,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_addr_ok_i,
    input  logic        ibus_data_ok_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_exc_adel_o,
    output logic        fetch_timeout_o
);

    localparam int unsigned    CntW   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic            drop_q, drop_d;
    logic [31:0]     addr_q, addr_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [31:0]     inst_pc_q, inst_pc_d;
    logic            exc_q, exc_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;
    logic            bus_busy;

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign ibus_req_o      = (state_q == StAddr);
    assign ibus_addr_o     = addr_q;
    assign inst_valid_o    = inst_valid_q;
    assign inst_o          = inst_q;
    assign inst_pc_o       = inst_pc_q;
    assign inst_exc_adel_o = exc_q;
    assign fetch_timeout_o = timeout_q;

    // Handoff: flush always wins over a pending handoff.
    assign pc_en_o = inst_valid_q & ~stall_i & ~flush;

    assign bus_busy = (state_q == StAddr) || (state_q == StData);

    // ---------------------------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        addr_d       = addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        exc_d        = exc_q;

        unique case (state_q)
            StIdle: begin
                // On flush the PC register is loading the new target this edge; pc_i is
                // only meaningful again next cycle.
                if (!flush) begin
                    if (pc_i[1:0] != 2'b00) begin
                        state_d      = StHold;
                        inst_valid_d = 1'b1;
                        inst_d       = 32'h0;
                        inst_pc_d    = pc_i;
                        exc_d        = 1'b1;
                    end else begin
                        // addr_q doubles as the latched PC of the instruction in flight.
                        addr_d  = pc_i;
                        state_d = StAddr;
                    end
                end
            end

            StAddr: begin
                // The request is never withdrawn; a flush only marks the result for discard.
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (ibus_addr_ok_i) begin
                    state_d = StData;
                end
            end

            StData: begin
                if (ibus_data_ok_i) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d      = StHold;
                        inst_valid_d = 1'b1;
                        inst_d       = ibus_rdata_i;
                        inst_pc_d    = addr_q;
                        exc_d        = 1'b0;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end

            StHold: begin
                if (flush || pc_en_o) begin
                    inst_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Bus wait counter: counts cycles spent in one bus phase, restarts on every state change
    // ---------------------------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (bus_busy && (wait_cnt_q != MaxCnt)) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
        timeout_d = timeout_q | (wait_cnt_q == MaxCnt);
    end

    // ---------------------------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            drop_q       <= 1'b0;
            addr_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= RESET_PC;
            exc_q        <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            addr_q       <= addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            exc_q        <= exc_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit. A small PC-register model feeds pc_i. Bus stimulus is
// driven 1 time unit after the rising edge; every handed-off instruction (inst_valid_o and
// pc_en_o both high) is popped from an expected-instruction queue on the falling edge.
// ---------------------------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush;
    logic        stall_i;
    logic        pc_en_o;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_addr_ok_i;
    logic        ibus_data_ok_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_exc_adel_o;
    logic        fetch_timeout_o;

    logic [31:0] flush_target;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(
        .RESET_PC (32'hbfc00000),
        .MAX_WAIT (255)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .flush           (flush),
        .stall_i         (stall_i),
        .pc_en_o         (pc_en_o),
        .ibus_req_o      (ibus_req_o),
        .ibus_addr_o     (ibus_addr_o),
        .ibus_addr_ok_i  (ibus_addr_ok_i),
        .ibus_data_ok_i  (ibus_data_ok_i),
        .ibus_rdata_i    (ibus_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_exc_adel_o (inst_exc_adel_o),
        .fetch_timeout_o (fetch_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model
    always @(posedge clk) begin
        if (rst) begin
            pc_i <= 32'hbfc00000;
        end else if (flush) begin
            pc_i <= flush_target;
        end else if (pc_en_o) begin
            pc_i <= pc_i + 32'd4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: compares every handoff against the oldest expected instruction.
    always @(negedge clk) begin
        if (!rst && inst_valid_o && pc_en_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handoff_unexpected: got inst %h pc %h, required no handoff",
                         inst_o, inst_pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("handoff_inst", inst_o, mon_e.inst);
                check("handoff_pc", inst_pc_o, mon_e.pc);
                check("handoff_exc", {31'b0, inst_exc_adel_o}, {31'b0, mon_e.exc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until ibus_req_o rises (bounded), then checks the address.
    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        step();
        while (!ibus_req_o && n < 20) begin
            step();
            n++;
        end
        check("req_seen", {31'b0, ibus_req_o}, 32'd1);
        check("req_addr", ibus_addr_o, exp_addr);
    endtask

    // One complete fetch with aw address wait cycles and dw data wait cycles. Returns one
    // unit after the edge on which the DUT captured the read data.
    task automatic bus_fetch(input logic [31:0] exp_addr, input int aw, input int dw,
                             input logic [31:0] data);
        bit stable = 1'b1;
        wait_req(exp_addr);
        for (int i = 0; i < aw; i++) begin
            step();
            if (!ibus_req_o || ibus_addr_o !== exp_addr) stable = 1'b0;
        end
        check("req_held_during_wait", {31'b0, stable}, 32'd1);
        ibus_addr_ok_i = 1'b1;
        step();
        ibus_addr_ok_i = 1'b0;
        check("req_drops_after_addr_ok", {31'b0, ibus_req_o}, 32'd0);
        for (int i = 0; i < dw; i++) step();
        ibus_data_ok_i = 1'b1;
        ibus_rdata_i   = data;
        exp_q.push_back('{inst: data, pc: exp_addr, exc: 1'b0});
        step();
        ibus_data_ok_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit stable;
        rst            = 1'b1;
        flush          = 1'b0;
        flush_target   = 32'h0;
        stall_i        = 1'b0;
        ibus_addr_ok_i = 1'b0;
        ibus_data_ok_i = 1'b0;
        ibus_rdata_i   = 32'h0;

        // Reset values
        repeat (3) step();
        check("rst_req", {31'b0, ibus_req_o}, 32'd0);
        check("rst_addr", ibus_addr_o, 32'h0);
        check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_inst_pc", inst_pc_o, 32'hbfc00000);
        check("rst_exc", {31'b0, inst_exc_adel_o}, 32'd0);
        check("rst_timeout", {31'b0, fetch_timeout_o}, 32'd0);
        check("rst_pc_en", {31'b0, pc_en_o}, 32'd0);
        rst = 1'b0;

        // Zero-wait fetch; pc_en_o pulses for a single cycle
        bus_fetch(32'hbfc00000, 0, 0, 32'h24080001);
        check("zw_valid", {31'b0, inst_valid_o}, 32'd1);
        check("zw_pc_en", {31'b0, pc_en_o}, 32'd1);
        step();
        check("zw_pc_en_pulse_end", {31'b0, pc_en_o}, 32'd0);
        check("zw_valid_clear", {31'b0, inst_valid_o}, 32'd0);

        // Downstream stall for 3 cycles in HOLD
        stall_i = 1'b1;
        bus_fetch(32'hbfc00004, 1, 1, 32'h3c011234);
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", {31'b0, inst_valid_o}, 32'd1);
            check("stall_pc_en", {31'b0, pc_en_o}, 32'd0);
            check("stall_inst", inst_o, 32'h3c011234);
            check("stall_inst_pc", inst_pc_o, 32'hbfc00004);
            if (k < 2) step();
        end
        stall_i = 1'b0;
        #1;
        check("stall_release_pc_en", {31'b0, pc_en_o}, 32'd1);
        step();
        check("stall_handoff_done", {31'b0, inst_valid_o}, 32'd0);

        // Flush one cycle after addr_ok; data_ok two cycles later is discarded
        wait_req(32'hbfc00008);
        ibus_addr_ok_i = 1'b1;
        step();
        ibus_addr_ok_i = 1'b0;
        flush          = 1'b1;
        flush_target   = 32'h80000180;
        step();
        flush = 1'b0;
        step();
        ibus_data_ok_i = 1'b1;
        ibus_rdata_i   = 32'hdeadbeef;
        step();
        ibus_data_ok_i = 1'b0;
        check("fdata_no_valid", {31'b0, inst_valid_o}, 32'd0);
        check("fdata_idle", {31'b0, ibus_req_o}, 32'd0);
        bus_fetch(32'h80000180, 0, 0, 32'h8c020010);

        // Flush coincident with data_ok
        wait_req(32'h80000184);
        ibus_addr_ok_i = 1'b1;
        step();
        ibus_addr_ok_i = 1'b0;
        ibus_data_ok_i = 1'b1;
        ibus_rdata_i   = 32'h11111111;
        flush          = 1'b1;
        flush_target   = 32'h80000200;
        #1;
        check("fco_pc_en", {31'b0, pc_en_o}, 32'd0);
        step();
        ibus_data_ok_i = 1'b0;
        flush          = 1'b0;
        check("fco_no_valid", {31'b0, inst_valid_o}, 32'd0);
        check("fco_idle_no_req", {31'b0, ibus_req_o}, 32'd0);
        check("fco_no_pc_en", {31'b0, pc_en_o}, 32'd0);
        bus_fetch(32'h80000200, 2, 3, 32'hac030004);
        step();

        // Misaligned PC, then flush while holding the exception
        flush        = 1'b1;
        flush_target = 32'hbfc00002;
        stall_i      = 1'b1;
        step();
        flush = 1'b0;
        check("mis_idle_no_req", {31'b0, ibus_req_o}, 32'd0);
        step();
        check("mis_no_req", {31'b0, ibus_req_o}, 32'd0);
        check("mis_valid", {31'b0, inst_valid_o}, 32'd1);
        check("mis_exc", {31'b0, inst_exc_adel_o}, 32'd1);
        check("mis_inst", inst_o, 32'h0);
        check("mis_inst_pc", inst_pc_o, 32'hbfc00002);
        flush        = 1'b1;
        flush_target = 32'hbfc00010;
        #1;
        check("hold_flush_pc_en", {31'b0, pc_en_o}, 32'd0);
        step();
        flush   = 1'b0;
        stall_i = 1'b0;
        check("hold_flush_valid", {31'b0, inst_valid_o}, 32'd0);
        check("hold_flush_no_req", {31'b0, ibus_req_o}, 32'd0);
        bus_fetch(32'hbfc00010, 0, 1, 32'h00851021);

        // Bus hang: addr_ok withheld for 300 cycles
        wait_req(32'hbfc00014);
        stable = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (!ibus_req_o || ibus_addr_o !== 32'hbfc00014) stable = 1'b0;
            if (i == 100) check("hang_timeout_early", {31'b0, fetch_timeout_o}, 32'd0);
        end
        check("hang_req_stable", {31'b0, stable}, 32'd1);
        check("hang_timeout_set", {31'b0, fetch_timeout_o}, 32'd1);
        ibus_addr_ok_i = 1'b1;
        step();
        ibus_addr_ok_i = 1'b0;
        ibus_data_ok_i = 1'b1;
        ibus_rdata_i   = 32'h8fbf0018;
        exp_q.push_back('{inst: 32'h8fbf0018, pc: 32'hbfc00014, exc: 1'b0});
        step();
        ibus_data_ok_i = 1'b0;
        check("hang_timeout_sticky", {31'b0, fetch_timeout_o}, 32'd1);
        step();
        rst = 1'b1;
        step();
        check("rst2_timeout", {31'b0, fetch_timeout_o}, 32'd0);
        check("rst2_valid", {31'b0, inst_valid_o}, 32'd0);
        check("rst2_req", {31'b0, ibus_req_o}, 32'd0);
        rst = 1'b0;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
